// File: rtl/ripple_count_sampler_if.sv
// Result port of ripple_count_sampler: valid/ready handshake carrying the running total and the delta.
// The master drives the result and the slave consumes it.
interface ripple_count_sampler_if #(
    parameter int ACC_W   = 16,
    parameter int DELTA_W = 8
);
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_total;
    logic [DELTA_W-1:0] out_delta;

    modport master (
        output out_valid,
        output out_total,
        output out_delta,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_total,
        input  out_delta,
        output out_ready
    );
endinterface

// File: rtl/ripple_count_sampler.sv
// Synchronises and de-glitches a 4-bit ripple counter, accumulates modulo-16 deltas, presents them on valid/ready.
// Optional sticky accumulator-overflow flag acc_wrap is enabled by defining RCS_WRAP_FLAG_EN.
module ripple_count_sampler #(
    parameter int ACC_W      = 16,
    parameter int DELTA_W    = 8,
    parameter int STABLE_CNT = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [3:0]             cnt_in,
    input  logic                   enable,
    ripple_count_sampler_if.master out_bus
`ifdef RCS_WRAP_FLAG_EN
    ,
    output logic                   acc_wrap
`endif
);
    localparam int HOLD_W = $clog2(STABLE_CNT + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STABLE_CNT);

    logic [3:0]         sync1;
    logic [3:0]         sync2;
    logic [3:0]         baseline;
    logic [HOLD_W-1:0]  hold;
    logic [HOLD_W-1:0]  hold_next;
    logic               primed;
    logic [ACC_W-1:0]   acc;
    logic [ACC_W-1:0]   acc_next;
    logic [DELTA_W-1:0] pend;
    logic [DELTA_W-1:0] pend_sat;
    logic [DELTA_W:0]   pend_sum;
    logic [3:0]         delta;
    logic               stable_hit;
    logic               event_fire;
`ifdef RCS_WRAP_FLAG_EN
    logic               acc_carry;
`endif

    // hold counts edges the value entering sync2 (sync1) has been held; stable_hit fires once per new value
    always_comb begin
        hold_next = HOLD_W'(1);
        if (sync1 == sync2) begin
            hold_next = (hold == HOLD_MAX) ? hold : hold + HOLD_W'(1);
        end
        stable_hit = (hold_next == HOLD_MAX) && ((hold != HOLD_MAX) || (sync1 != sync2));
        event_fire = stable_hit && primed && enable && (sync1 != baseline);
        delta      = sync1 - baseline;
`ifdef RCS_WRAP_FLAG_EN
        {acc_carry, acc_next} = {1'b0, acc} + (ACC_W + 1)'(delta);
`else
        acc_next = acc + ACC_W'(delta);
`endif
        pend_sum = {1'b0, pend} + (DELTA_W + 1)'(delta);
        pend_sat = pend_sum[DELTA_W] ? {DELTA_W{1'b1}} : pend_sum[DELTA_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= '0;
            sync2    <= '0;
            hold     <= '0;
            baseline <= '0;
            primed   <= 1'b0;
            acc      <= '0;
        end else begin
            sync1 <= cnt_in;
            sync2 <= sync1;
            hold  <= hold_next;
            if (stable_hit) begin
                baseline <= sync1;
                primed   <= 1'b1;
            end
            if (event_fire) begin
                acc <= acc_next;
            end
        end
    end

    // A held result absorbs new deltas into pend; a handshake re-presents pend before dropping valid
    always_ff @(posedge clk) begin
        if (reset) begin
            out_bus.out_valid <= 1'b0;
            out_bus.out_total <= '0;
            out_bus.out_delta <= '0;
            pend              <= '0;
        end else if (event_fire && (!out_bus.out_valid || out_bus.out_ready)) begin
            out_bus.out_valid <= 1'b1;
            out_bus.out_total <= acc_next;
            out_bus.out_delta <= pend_sat;
            pend              <= '0;
        end else if (event_fire) begin
            pend <= pend_sat;
        end else if (out_bus.out_valid && out_bus.out_ready) begin
            if (pend != '0) begin
                out_bus.out_total <= acc;
                out_bus.out_delta <= pend;
                pend              <= '0;
            end else begin
                out_bus.out_valid <= 1'b0;
            end
        end
    end

`ifdef RCS_WRAP_FLAG_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_wrap <= 1'b0;
        end else if (event_fire && acc_carry) begin
            acc_wrap <= 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_ripple_count_sampler.sv
// Directed table-driven bench for ripple_count_sampler; a second instance with narrow widths covers wrap and saturation.
// Define RCS_WRAP_FLAG_EN to also check the acc_wrap flag.
module tb_ripple_count_sampler;
    logic       clk;
    logic       reset;
    logic [3:0] cnt_in;
    logic       enable;
    logic       ready;
    int         checks;
    int         failures;

    ripple_count_sampler_if #(.ACC_W(16), .DELTA_W(8)) bus_a ();
    ripple_count_sampler_if #(.ACC_W(4), .DELTA_W(4)) bus_b ();

    assign bus_a.out_ready = ready;
    assign bus_b.out_ready = ready;

`ifdef RCS_WRAP_FLAG_EN
    logic wrap_a;
    logic wrap_b;
`endif

    ripple_count_sampler #(.ACC_W(16), .DELTA_W(8), .STABLE_CNT(2)) dut_a (
        .clk     (clk),
        .reset   (reset),
        .cnt_in  (cnt_in),
        .enable  (enable),
        .out_bus (bus_a.master)
`ifdef RCS_WRAP_FLAG_EN
        ,
        .acc_wrap(wrap_a)
`endif
    );

    ripple_count_sampler #(.ACC_W(4), .DELTA_W(4), .STABLE_CNT(2)) dut_b (
        .clk     (clk),
        .reset   (reset),
        .cnt_in  (cnt_in),
        .enable  (enable),
        .out_bus (bus_b.master)
`ifdef RCS_WRAP_FLAG_EN
        ,
        .acc_wrap(wrap_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] cnt;
        logic       en;
        logic       rdy;
        int         n;
        logic       exp_valid;
        int         exp_total;
        int         exp_delta;
    } vec_t;

    vec_t vecs[29];

    task automatic apply_stimulus(input logic [3:0] c, input logic e, input logic r, input int n);
        cnt_in = c;
        enable = e;
        ready  = r;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic check_b(input string tag, input int v, input int t, input int d);
        check_output({tag, "_valid"}, int'(bus_b.out_valid), v);
        if (v != 0) begin
            check_output({tag, "_total"}, int'(bus_b.out_total), t);
            check_output({tag, "_delta"}, int'(bus_b.out_delta), d);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        // cnt, en, rdy, edges, exp_valid, exp_total, exp_delta
        vecs[0]  = '{4'h5, 1'b1, 1'b1, 4, 1'b0, 0, 0};
        vecs[1]  = '{4'h6, 1'b1, 1'b1, 2, 1'b0, 0, 0};
        vecs[2]  = '{4'h6, 1'b1, 1'b1, 1, 1'b1, 1, 1};
        vecs[3]  = '{4'h6, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[4]  = '{4'h7, 1'b1, 1'b1, 3, 1'b1, 2, 1};
        vecs[5]  = '{4'h7, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[6]  = '{4'h6, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[7]  = '{4'h4, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[8]  = '{4'h8, 1'b1, 1'b1, 2, 1'b0, 0, 0};
        vecs[9]  = '{4'h8, 1'b1, 1'b1, 1, 1'b1, 3, 1};
        vecs[10] = '{4'h8, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[11] = '{4'hE, 1'b1, 1'b1, 3, 1'b1, 9, 6};
        vecs[12] = '{4'hE, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[13] = '{4'h2, 1'b1, 1'b1, 3, 1'b1, 13, 4};
        vecs[14] = '{4'h2, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[15] = '{4'h9, 1'b0, 1'b1, 3, 1'b0, 0, 0};
        vecs[16] = '{4'h9, 1'b0, 1'b1, 2, 1'b0, 0, 0};
        vecs[17] = '{4'hA, 1'b1, 1'b1, 3, 1'b1, 14, 1};
        vecs[18] = '{4'hA, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[19] = '{4'hC, 1'b1, 1'b0, 3, 1'b1, 16, 2};
        vecs[20] = '{4'hE, 1'b1, 1'b0, 3, 1'b1, 16, 2};
        vecs[21] = '{4'h0, 1'b1, 1'b0, 3, 1'b1, 16, 2};
        vecs[22] = '{4'h0, 1'b1, 1'b1, 1, 1'b1, 20, 4};
        vecs[23] = '{4'h0, 1'b1, 1'b1, 1, 1'b0, 0, 0};
        vecs[24] = '{4'h2, 1'b1, 1'b0, 3, 1'b1, 22, 2};
        vecs[25] = '{4'h3, 1'b1, 1'b0, 3, 1'b1, 22, 2};
        vecs[26] = '{4'h5, 1'b1, 1'b0, 2, 1'b1, 22, 2};
        vecs[27] = '{4'h5, 1'b1, 1'b1, 1, 1'b1, 25, 3};
        vecs[28] = '{4'h5, 1'b1, 1'b1, 1, 1'b0, 0, 0};

        reset = 1'b1;
        apply_stimulus(4'h5, 1'b1, 1'b1, 2);
        check_output("rst_valid", int'(bus_a.out_valid), 0);
        check_output("rst_total", int'(bus_a.out_total), 0);
        check_output("rst_delta", int'(bus_a.out_delta), 0);
        reset = 1'b0;

        for (int i = 0; i < 29; i++) begin
            apply_stimulus(vecs[i].cnt, vecs[i].en, vecs[i].rdy, vecs[i].n);
            check_output($sformatf("v%0d_valid", i), int'(bus_a.out_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) begin
                check_output($sformatf("v%0d_total", i), int'(bus_a.out_total), vecs[i].exp_total);
                check_output($sformatf("v%0d_delta", i), int'(bus_a.out_delta), vecs[i].exp_delta);
            end
        end

        // Narrow instance: 4-bit total wraps, 4-bit pending delta saturates at 15
        reset = 1'b1;
        apply_stimulus(4'h0, 1'b1, 1'b1, 2);
        check_b("b_rst", 0, 0, 0);
        check_output("b_rst_total", int'(bus_b.out_total), 0);
`ifdef RCS_WRAP_FLAG_EN
        check_output("b_rst_wrap", int'(wrap_b), 0);
`endif
        reset = 1'b0;
        apply_stimulus(4'h0, 1'b1, 1'b1, 4);
        check_b("b_prime", 0, 0, 0);
        apply_stimulus(4'hF, 1'b1, 1'b0, 3);
        check_b("b_first", 1, 15, 15);
`ifdef RCS_WRAP_FLAG_EN
        check_output("b_wrap_before", int'(wrap_b), 0);
`endif
        apply_stimulus(4'h0, 1'b1, 1'b0, 3);
        check_b("b_held1", 1, 15, 15);
`ifdef RCS_WRAP_FLAG_EN
        check_output("b_wrap_set", int'(wrap_b), 1);
`endif
        apply_stimulus(4'hF, 1'b1, 1'b0, 3);
        check_b("b_held2", 1, 15, 15);
        apply_stimulus(4'hF, 1'b1, 1'b1, 1);
        check_b("b_sat", 1, 15, 15);
        apply_stimulus(4'hF, 1'b1, 1'b1, 1);
        check_b("b_drain", 0, 0, 0);
        apply_stimulus(4'h1, 1'b1, 1'b1, 3);
        check_b("b_wrapped", 1, 1, 2);
`ifdef RCS_WRAP_FLAG_EN
        check_output("b_wrap_sticky", int'(wrap_b), 1);
`endif
        reset = 1'b1;
        apply_stimulus(4'h1, 1'b1, 1'b0, 1);
        check_b("b_midrst", 0, 0, 0);
        check_output("a_midrst_valid", int'(bus_a.out_valid), 0);
`ifdef RCS_WRAP_FLAG_EN
        check_output("b_wrap_clr", int'(wrap_b), 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
